// File: rtl/neurone.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | neurone: 9-input MAC neuron. One shared multiplier over 9 cycles, then     |
// |          an arithmetic right shift and saturation to 34 bits signed.        |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module neurone #(
    parameter int FRAC_BITS = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_,
    input  logic signed [32:0] input_0,
    input  logic signed [32:0] input_1,
    input  logic signed [32:0] input_2,
    input  logic signed [32:0] input_3,
    input  logic signed [32:0] input_4,
    input  logic signed [32:0] input_5,
    input  logic signed [32:0] input_6,
    input  logic signed [32:0] input_7,
    input  logic signed [32:0] input_8,
    input  logic signed [32:0] weight_0,
    input  logic signed [32:0] weight_1,
    input  logic signed [32:0] weight_2,
    input  logic signed [32:0] weight_3,
    input  logic signed [32:0] weight_4,
    input  logic signed [32:0] weight_5,
    input  logic signed [32:0] weight_6,
    input  logic signed [32:0] weight_7,
    input  logic signed [32:0] weight_8,
    output logic signed [33:0] out,
    output logic               end_
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic signed [69:0] SAT_MAX = 70'sd8589934591;
    localparam logic signed [69:0] SAT_MIN = -70'sd8589934592;

    state_t             state_q, state_d;
    logic signed [32:0] in_q   [9];
    logic signed [32:0] in_d   [9];
    logic signed [32:0] w_q    [9];
    logic signed [32:0] w_d    [9];
    logic signed [32:0] in_vec [9];
    logic signed [32:0] w_vec  [9];
    logic        [3:0]  idx_q, idx_d;
    logic signed [69:0] acc_q, acc_d;
    logic signed [33:0] out_q, out_d;
    logic               end_q, end_d;
    logic signed [65:0] prod;
    logic signed [69:0] shifted;

    always_comb begin
        in_vec[0] = input_0;  w_vec[0] = weight_0;
        in_vec[1] = input_1;  w_vec[1] = weight_1;
        in_vec[2] = input_2;  w_vec[2] = weight_2;
        in_vec[3] = input_3;  w_vec[3] = weight_3;
        in_vec[4] = input_4;  w_vec[4] = weight_4;
        in_vec[5] = input_5;  w_vec[5] = weight_5;
        in_vec[6] = input_6;  w_vec[6] = weight_6;
        in_vec[7] = input_7;  w_vec[7] = weight_7;
        in_vec[8] = input_8;  w_vec[8] = weight_8;
    end

    always_comb begin
        prod    = in_q[idx_q] * w_q[idx_q];
        shifted = acc_q >>> FRAC_BITS;
    end

    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        w_d     = w_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        out_d   = out_q;
        end_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_) begin
                    in_d    = in_vec;
                    w_d     = w_vec;
                    acc_d   = '0;
                    idx_d   = 4'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + 70'(prod);
                if (idx_q == 4'd8) begin
                    idx_d   = 4'd0;
                    state_d = FINISH;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            FINISH: begin
                // Shift is arithmetic, so negative sums floor toward -inf.
                if (shifted > SAT_MAX) begin
                    out_d = 34'sh1FFFFFFFF;
                end else if (shifted < SAT_MIN) begin
                    out_d = 34'sh200000000;
                end else begin
                    out_d = shifted[33:0];
                end
                end_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            acc_q   <= '0;
            out_q   <= '0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            end_q   <= end_d;
        end
    end

    // Operand latches only need to be valid once a start has been accepted.
    always_ff @(posedge clk) begin
        in_q <= in_d;
        w_q  <= w_d;
    end

    assign out  = out_q;
    assign end_ = end_q;

endmodule
`default_nettype wire

// File: tb/tb_neurone.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_neurone: three neurone instances (FRAC_BITS 0, 1, 24) on shared inputs, |
// |             checked against an arithmetic reference model.                  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_neurone;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start_;
    logic signed [32:0] in_v [9];
    logic signed [32:0] w_v  [9];
    logic signed [33:0] out0, out1, out24;
    logic               end0, end1, end24;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    neurone #(.FRAC_BITS(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_(start_),
        .input_0(in_v[0]), .input_1(in_v[1]), .input_2(in_v[2]),
        .input_3(in_v[3]), .input_4(in_v[4]), .input_5(in_v[5]),
        .input_6(in_v[6]), .input_7(in_v[7]), .input_8(in_v[8]),
        .weight_0(w_v[0]), .weight_1(w_v[1]), .weight_2(w_v[2]),
        .weight_3(w_v[3]), .weight_4(w_v[4]), .weight_5(w_v[5]),
        .weight_6(w_v[6]), .weight_7(w_v[7]), .weight_8(w_v[8]),
        .out(out0), .end_(end0)
    );

    neurone #(.FRAC_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_(start_),
        .input_0(in_v[0]), .input_1(in_v[1]), .input_2(in_v[2]),
        .input_3(in_v[3]), .input_4(in_v[4]), .input_5(in_v[5]),
        .input_6(in_v[6]), .input_7(in_v[7]), .input_8(in_v[8]),
        .weight_0(w_v[0]), .weight_1(w_v[1]), .weight_2(w_v[2]),
        .weight_3(w_v[3]), .weight_4(w_v[4]), .weight_5(w_v[5]),
        .weight_6(w_v[6]), .weight_7(w_v[7]), .weight_8(w_v[8]),
        .out(out1), .end_(end1)
    );

    neurone #(.FRAC_BITS(24)) u_dut24 (
        .clk(clk), .rst_n(rst_n), .start_(start_),
        .input_0(in_v[0]), .input_1(in_v[1]), .input_2(in_v[2]),
        .input_3(in_v[3]), .input_4(in_v[4]), .input_5(in_v[5]),
        .input_6(in_v[6]), .input_7(in_v[7]), .input_8(in_v[8]),
        .weight_0(w_v[0]), .weight_1(w_v[1]), .weight_2(w_v[2]),
        .weight_3(w_v[3]), .weight_4(w_v[4]), .weight_5(w_v[5]),
        .weight_6(w_v[6]), .weight_7(w_v[7]), .weight_8(w_v[8]),
        .out(out24), .end_(end24)
    );

    task automatic check(input string tag, input logic signed [127:0] got,
                         input logic signed [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Dot product in wide integer arithmetic, floor-divide by 2^frac, clamp.
    function automatic logic signed [127:0] model(input int frac);
        logic signed [127:0] s;
        logic signed [127:0] a;
        logic signed [127:0] b;
        s = 0;
        for (int i = 0; i < 9; i++) begin
            a = in_v[i];
            b = w_v[i];
            s = s + a * b;
        end
        s = s >>> frac;
        if (s > 128'sd8589934591)  s = 128'sd8589934591;
        if (s < -128'sd8589934592) s = -128'sd8589934592;
        return s;
    endfunction

    function automatic logic signed [32:0] rnd33();
        logic [63:0] t;
        int          v;
        t = {$urandom(), $urandom()};
        case ($urandom_range(0, 2))
            0: begin
                v = int'($urandom_range(0, 200)) - 100;
                return 33'(v);
            end
            1: return t[32:0];
            default: return ($urandom_range(0, 1) == 1) ? 33'sh0FFFFFFFF : 33'sh100000000;
        endcase
    endfunction

    task automatic load_nominal();
        for (int i = 0; i < 9; i++) in_v[i] = 33'(i + 1);
        w_v[0] = 33'sd14264025;  w_v[1] = 33'sd20602356;  w_v[2] = 33'sd62294483;
        w_v[3] = -33'sd5274598;  w_v[4] = 33'sd61604893;  w_v[5] = -33'sd5720134;
        w_v[6] = 33'sd27585557;  w_v[7] = -33'sd11946924; w_v[8] = 33'sd17072096;
    endtask

    task automatic load_fill(input logic signed [32:0] iv, input logic signed [32:0] wv);
        for (int i = 0; i < 9; i++) begin
            in_v[i] = iv;
            w_v[i]  = wv;
        end
    endtask

    // One start pulse; optional disturbance of inputs and start_ while busy.
    task automatic run_op(input string tag, input bit disturb);
        logic signed [127:0] e0, e1, e24;
        int lat;
        int extra;
        e0  = model(0);
        e1  = model(1);
        e24 = model(24);
        @(negedge clk); start_ = 1'b1;
        @(posedge clk);
        @(negedge clk); start_ = 1'b0;
        lat = 0;
        while (!end0 && lat < 20) begin
            @(negedge clk);
            lat++;
            if (disturb && lat == 2) begin
                load_fill(33'sd0, 33'sd0);
                start_ = 1'b1;
            end
            if (disturb && lat == 3) start_ = 1'b0;
        end
        check({tag, "_latency"}, lat, 10);
        check({tag, "_end1"}, end1, 1);
        check({tag, "_end24"}, end24, 1);
        check({tag, "_out0"}, out0, e0);
        check({tag, "_out1"}, out1, e1);
        check({tag, "_out24"}, out24, e24);
        @(negedge clk);
        check({tag, "_end_drop"}, end0, 0);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (end0) extra++;
        end
        check({tag, "_no_extra_end"}, extra, 0);
    endtask

    initial begin
        int pulses;
        int last;
        rst_n  = 1'b0;
        start_ = 1'b0;
        load_fill(33'sd0, 33'sd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("por_out", out0, 0);
        check("por_end", end0, 0);
        rst_n = 1'b1;

        load_nominal();
        run_op("nominal", 1'b0);
        check("nominal_out0_const", out0, 746129826);
        check("nominal_out24_const", out24, 44);

        load_fill(33'sh0FFFFFFFF, 33'sh0FFFFFFFF);
        run_op("sat_pos", 1'b0);
        check("sat_pos_const", out0, 128'sd8589934591);

        load_fill(33'sh0FFFFFFFF, 33'sh100000000);
        run_op("sat_neg", 1'b0);
        check("sat_neg_const", out0, -128'sd8589934592);

        load_fill(33'sd0, 33'sd0);
        in_v[0] = -33'sd1;
        w_v[0]  = 33'sd1;
        run_op("floor", 1'b0);
        check("floor_const", out1, -1);

        load_fill(33'sd0, 33'sd0);
        run_op("zeros", 1'b0);
        check("zeros_const", out0, 0);

        load_nominal();
        run_op("isolate", 1'b1);
        check("isolate_const", out0, 746129826);

        // Reset mid-operation.
        load_nominal();
        @(negedge clk); start_ = 1'b1;
        @(posedge clk);
        @(negedge clk); start_ = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (end0) pulses++;
        end
        check("abort_no_end", pulses, 0);
        check("abort_out0", out0, 0);
        check("abort_out24", out24, 0);
        run_op("after_reset", 1'b0);

        // Continuous start.
        load_nominal();
        @(negedge clk); start_ = 1'b1;
        @(posedge clk);
        pulses = 0;
        last   = -1;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            if (end0) begin
                pulses++;
                check("cont_out", out0, 746129826);
                if (last < 0) check("cont_first", c, 10);
                else          check("cont_period", c - last, 11);
                last = c;
            end
        end
        check("cont_pulses", pulses, 3);
        start_ = 1'b0;
        repeat (20) @(negedge clk);

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 9; i++) begin
                in_v[i] = rnd33();
                w_v[i]  = rnd33();
            end
            run_op("random", ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
